// File: rtl/key_dispatcher.sv
// Shared-counter RC4 key dispatcher: round-robin grants one requesting core per cycle with the next key,
// registered one cycle after req is sampled; KEY_DISPATCH_RESUME_EN makes start-after-stop resume the key sequence.
module key_dispatcher #(
  parameter int NUM_CORES     = 69,
  parameter int LOG_NUM_CORES = 8,
  parameter int KEY_LENGTH    = 3,
  parameter int RAM_WIDTH     = 8,
  parameter logic [KEY_LENGTH*RAM_WIDTH-1:0] KEY_MIN = '0,
  parameter logic [KEY_LENGTH*RAM_WIDTH-1:0] KEY_MAX = '1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              stop,
  input  logic [NUM_CORES-1:0]              req,
  output logic [NUM_CORES-1:0]              grant,
  output logic [LOG_NUM_CORES-1:0]          grant_idx,
  output logic [KEY_LENGTH*RAM_WIDTH-1:0]   grant_key,
  output logic                              busy,
  output logic                              exhausted
);

  localparam int KW = KEY_LENGTH * RAM_WIDTH;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DISPATCH = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;

  logic [1:0]               state;
  logic [KW:0]              next_key;
  logic [LOG_NUM_CORES-1:0] last_idx;

  logic [NUM_CORES-1:0]     masked;
  logic                     found_hi;
  logic                     found_lo;
  logic [LOG_NUM_CORES-1:0] pick_hi;
  logic [LOG_NUM_CORES-1:0] pick_lo;
  logic [NUM_CORES-1:0]     hot_hi;
  logic [NUM_CORES-1:0]     hot_lo;
  logic                     found;
  logic [LOG_NUM_CORES-1:0] pick;
  logic [NUM_CORES-1:0]     hot;
  logic                     at_max;

  // Round-robin split into two priority searches: cores above last_idx first, then wrap to the rest.
  always_comb begin
    masked   = req & ~grant;
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    hot_hi   = '0;
    hot_lo   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (masked[i]) begin
        if (LOG_NUM_CORES'(i) > last_idx) begin
          if (!found_hi) begin
            found_hi  = 1'b1;
            pick_hi   = LOG_NUM_CORES'(i);
            hot_hi[i] = 1'b1;
          end
        end else begin
          if (!found_lo) begin
            found_lo  = 1'b1;
            pick_lo   = LOG_NUM_CORES'(i);
            hot_lo[i] = 1'b1;
          end
        end
      end
    end
    found = found_hi | found_lo;
    pick  = found_hi ? pick_hi : pick_lo;
    hot   = found_hi ? hot_hi : hot_lo;
  end

  assign at_max = (next_key == {1'b0, KEY_MAX});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      next_key  <= {1'b0, KEY_MIN};
      last_idx  <= LOG_NUM_CORES'(NUM_CORES - 1);
      grant     <= '0;
      grant_idx <= '0;
      grant_key <= '0;
      busy      <= 1'b0;
      exhausted <= 1'b0;
    end else begin
      grant <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= DISPATCH;
            busy      <= 1'b1;
            exhausted <= 1'b0;
            next_key  <= {1'b0, KEY_MIN};
          end
        end
        DISPATCH: begin
          if (stop) begin
            state <= DONE;
            busy  <= 1'b0;
          end else if (found) begin
            grant     <= hot;
            grant_idx <= pick;
            grant_key <= next_key[KW-1:0];
            next_key  <= next_key + (KW+1)'(1);
            last_idx  <= pick;
            if (at_max) begin
              state     <= DONE;
              busy      <= 1'b0;
              exhausted <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state     <= DISPATCH;
            busy      <= 1'b1;
            exhausted <= 1'b0;
`ifdef KEY_DISPATCH_RESUME_EN
            // After a stop next_key already points past the last issued key.
            if (exhausted) begin
              next_key <= {1'b0, KEY_MIN};
            end
`else
            next_key <= {1'b0, KEY_MIN};
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/key_dispatcher.md
# key_dispatcher

Hands out candidate RC4 keys to the parallel arcfour cracking cores on demand, replacing fixed per-core key ranges with a shared key counter. It sits directly upstream of the core array: each core raises a request when it is ready for a new key, and the dispatcher grants one core per cycle with the next key. A `stop` pulse halts issuance when any core reports success. An exhausted flag feeds the top-level fail decision.

## Interface
- `NUM_CORES`, 69: number of requesting cores.
- `LOG_NUM_CORES`, 8: width of the core index.
- `KEY_LENGTH`, 3: key bytes.
- `RAM_WIDTH`, 8: bits per key byte; key width `KW = KEY_LENGTH*RAM_WIDTH`.
- `KEY_MIN`, 0: first key issued.
- `KEY_MAX`, 24'hffffff: last key issued (inclusive).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: reset is asynchronous and active-low.
- `start`, in, 1: one-cycle pulse; begins or restarts dispatch.
- `stop`, in, 1: one-cycle pulse; halts dispatch (success found).
- `req`, in, NUM_CORES: per-core key request, level.
- `grant`, out, NUM_CORES: one-hot, one-cycle grant pulse.
- `grant_idx`, out, LOG_NUM_CORES: index of the granted core. Valid while `grant` is non-zero.
- `grant_key`, out, KW: key for the granted core. Valid while `grant` is non-zero.
- `busy`, out, 1: high in DISPATCH.
- `exhausted`, out, 1: high once `KEY_MAX` has been issued. Held until the next `start` or reset.

## Operation
- FSM states: IDLE, DISPATCH, DONE.
  - IDLE: `start` → DISPATCH, with `next_key` set to `KEY_MIN`.
  - DISPATCH: `stop` → DONE. Issuing `KEY_MAX` → DONE and set `exhausted`.
  - DONE: `start` → DISPATCH.
  - `start` in DISPATCH is ignored.
- Key counter:
  - `next_key` is KW+1 bits wide, so `KEY_MAX` = all-ones cannot wrap silently.
  - It increments by 1 per grant.
  - `grant_key` is `next_key[KW-1:0]`, registered with `grant`.
- Arbitration:
  - Round-robin over `req & ~grant` (a core granted this cycle is masked for one cycle, so it has time to drop `req`).
  - The search starts at `last_idx+1` mod NUM_CORES.
  - `last_idx` resets to NUM_CORES-1, so core 0 has first priority.
  - `last_idx` updates only on a grant.
- Grants occur only in DISPATCH. At most one core is granted per cycle. No grant is issued if the masked request vector is zero.
- Core contract: a core holds `req` until it sees `grant[i]`, and deasserts `req` in that same cycle.
- Reset values: `grant`=0, `grant_idx`=0, `grant_key`=0, `busy`=0, `exhausted`=0, state IDLE, `next_key`=`KEY_MIN`, `last_idx`=NUM_CORES-1.

## Timing
- `start` sampled at edge N → `busy`=1 after edge N.
- The first grant registers at edge N+1 at the earliest, from `req` sampled at N+1.
- Request-to-grant latency: 1 cycle when uncontended. Worst case NUM_CORES cycles under full contention.
- Throughput: one key per cycle.
- `stop` and a grant candidate in the same cycle: `stop` wins. No grant issues, and `next_key` is unchanged.
- `stop` and the `KEY_MAX` grant in the same cycle: `stop` wins, and `exhausted` stays 0.
- The grant of `KEY_MAX` registers together with `exhausted`=1 and `busy`=0 on the same edge.
- Reset asserted mid-dispatch: all outputs go to their reset values immediately, without waiting for a clock edge. An in-flight grant is lost.

## Configuration
- `KEY_DISPATCH_RESUME_EN`:
  - Defined: `start` from DONE after a `stop` continues from the key after the last one issued. `start` after exhaustion or from IDLE restarts at `KEY_MIN`.
  - Undefined: every `start` restarts at `KEY_MIN`.

## Test plan
- Round-robin order. NUM_CORES=4, KEY_MIN=0, KEY_MAX=15; start, then hold `req`=4'b1111.
  - Required: grants cycle through cores 0,1,2,3,0,1,2,3,… with keys 0,1,2,…,15 on consecutive cycles.
  - Required: `exhausted`=1 on the edge that issues key 15; no further grants.
- Fairness. `last_idx`=3, `req`=4'b1010.
  - Required: core 1 is granted, then core 3 the following cycle; core 3's `req` drops after its grant.
- Stop during run. Stop on the cycle that would issue key 7.
  - Required: no grant on that cycle, `busy`=0.
  - Required: a new `start` issues key 7 first when `KEY_DISPATCH_RESUME_EN` is defined, and key 0 otherwise.
- Stop collides with `KEY_MAX`. KEY_MAX=5, a single core requesting; stop coincides with the key-5 grant.
  - Required: no grant, `exhausted`=0, state DONE.
- Asynchronous reset. Assert `reset` low between clock edges mid-dispatch.
  - Required: `grant`, `grant_key`, `busy`, and `exhausted` read 0 before the next edge.
  - Required: after release, core 0 has first priority on the next `start`.
